timer_mode_ctrl: RTL and testbench
==================================

// Module: timer_mode_ctrl
// PURPOSE
//   Control FSM that sequences the mm:ss timer datapath. Debounces the four front-panel buttons and
//   tracks power/run/pause/set mode. Emits the 1 Hz count enable and single-cycle minute/second
//   increment strobes. The counter/display block consumes these strobes and holds no mode state itself.
// PARAMETERS
//   CLK_HZ          50_000_000  system clock frequency; prescaler terminal count = CLK_HZ-1
//   DEBOUNCE_MS     10          stable time before a button level is accepted
//   SET_TIMEOUT_S   10          idle time in a SET state before automatic exit to PAUSE
//   REPEAT_DELAY_MS 500         hold time before auto-repeat starts (AUTO_REPEAT_EN only)
//   REPEAT_RATE_MS  100         auto-repeat period (AUTO_REPEAT_EN only)
// PORTS
//   clk            in   1  system clock
//   rst            in   1  synchronous reset, active-high
//   btn_power      in   1  raw power button, active-high, asynchronous
//   btn_pause      in   1  raw pause/resume button, active-high, asynchronous
//   btn_set        in   1  raw set-mode/field-advance button, active-high, asynchronous
//   btn_inc        in   1  raw increment button, active-high, asynchronous
//   power_on       out  1  1 in every state except OFF
//   tick_1hz       out  1  one-cycle count enable to the datapath
//   inc_min        out  1  one-cycle minute increment strobe
//   inc_sec        out  1  one-cycle second increment strobe
//   set_field      out  2  00 none, 01 minutes, 10 seconds (field being edited)
//   blink          out  1  2 Hz square wave in SET states (digit flashing); 0 otherwise
//   led_state      out  1  1 only in RUN
// BEHAVIOUR
//   Reset: state OFF, all outputs 0, prescaler/blink/timeout counters 0, debouncers idle at level 0.
//   Inputs: 2-FF synchronizer, then debounce counter. Level accepted after DB=CLK_HZ/1000*DEBOUNCE_MS
//     stable cycles. Rising edge of the accepted level -> one-cycle press pulse.
//     Press latency = 2+DB+1 cycles after the raw edge. State update lands on the cycle after the pulse.
//   FSM states: OFF, RUN, PAUSE, SET_MIN, SET_SEC. Same-cycle press priority: power > set > pause > inc.
//     Lower-priority presses in that cycle are dropped.
//     OFF: power -> RUN; all other presses ignored.
//     any non-OFF: power -> OFF.
//     RUN: set -> SET_MIN; pause -> PAUSE.    PAUSE: set -> SET_MIN; pause -> RUN.
//     SET_MIN: set -> SET_SEC; inc -> inc_min. SET_SEC: set -> PAUSE; inc -> inc_sec.
//     SET states: pause presses ignored.
//     SET timeout: counter restarts on any press. Reaching SET_TIMEOUT_S*CLK_HZ cycles -> PAUSE.
//   Prescaler: advances only in RUN. Held (not cleared) in PAUSE and SET states. Cleared in OFF.
//     Wraps at CLK_HZ-1. tick_1hz is registered and asserted the cycle after the wrap.
//     A wrap on the same cycle as a RUN exit still produces its tick. No tick is ever emitted outside RUN+1.
//   inc_min/inc_sec: registered, one cycle per accepted press, never both in the same cycle.
//   set_field and led_state are decoded from the state register and change with it.
//   blink: counter free-runs in SET states at CLK_HZ/4 half-period, restarts at 1 on SET entry.
//   Reset mid-operation: state returns to OFF in one cycle and any pending strobes are discarded.
// CONFIGURATION
//   AUTO_REPEAT_EN defined: in SET states, btn_inc held past REPEAT_DELAY_MS emits an extra inc strobe
//     every REPEAT_RATE_MS until release or state change. Repeats also restart the SET timeout.
//   AUTO_REPEAT_EN undefined: exactly one strobe per press; repeat counters and parameters unused.
// STRUCTURE
//   Package timer_pkg: state encoding localparams, set_field codes, ms/s-to-cycles constant function.
//   Sub-module btn_debounce: synchronizer + debounce + press pulse, instantiated 4x.
//     Exposes the debounced level for the auto-repeat logic.
//   Top module contains the FSM, prescaler, timeout, blink and optional repeat logic.
// TESTING  (CLK_HZ=1000, DEBOUNCE_MS=2, SET_TIMEOUT_S=1, REPEAT_DELAY_MS=20, REPEAT_RATE_MS=5)
//   Reset, power press -> power_on=1, led_state=1; tick_1hz pulses exactly every 1000 cycles.
//   btn_pause toggling each cycle for 10 cycles, then held high -> exactly one press; PAUSE entered.
//     Prescaler value frozen; a second press resumes the count from that same value.
//   PAUSE, set, 3x inc, set, 1x inc, set -> set_field 01, 3 inc_min, set_field 10, 1 inc_sec.
//     Sequence ends in PAUSE with set_field 00.
//   RUN with power+set pressed on the same cycle -> OFF; no SET entry; no tick thereafter.
//   SET_MIN idle for 1000 cycles -> PAUSE. rst pulsed mid-RUN with prescaler=500 -> OFF; outputs and prescaler 0.
//   AUTO_REPEAT_EN: hold btn_inc 40 cycles in SET_SEC -> 1 + 4 inc_sec strobes (at press, +20, +25, +30, +35).

Source files
------------

// File: rtl/timer_mode_ctrl_pkg.sv
// Shared definitions for the mm:ss timer mode controller: state and
// set-field encodings plus time-to-cycle constant helpers.
package timer_pkg;

    localparam logic [2:0] S_OFF     = 3'd0;
    localparam logic [2:0] S_RUN     = 3'd1;
    localparam logic [2:0] S_PAUSE   = 3'd2;
    localparam logic [2:0] S_SET_MIN = 3'd3;
    localparam logic [2:0] S_SET_SEC = 3'd4;

    typedef enum logic [2:0] {
        ST_OFF     = S_OFF,
        ST_RUN     = S_RUN,
        ST_PAUSE   = S_PAUSE,
        ST_SET_MIN = S_SET_MIN,
        ST_SET_SEC = S_SET_SEC
    } state_t;

    localparam logic [1:0] FIELD_NONE = 2'b00;
    localparam logic [1:0] FIELD_MIN  = 2'b01;
    localparam logic [1:0] FIELD_SEC  = 2'b10;

    function automatic int ms_to_cycles(input int clk_hz, input int ms);
        return clk_hz / 1000 * ms;
    endfunction

    function automatic int s_to_cycles(input int clk_hz, input int s);
        return clk_hz * s;
    endfunction

    // Bits needed to hold values 0..maxval, never less than one.
    function automatic int cnt_width(input int maxval);
        return (maxval < 2) ? 1 : $clog2(maxval + 1);
    endfunction

endpackage

// File: rtl/timer_mode_ctrl_btn_debounce.sv
// Button conditioner: 2-FF synchronizer, stability counter, press pulse.
// Ports: clk, rst (sync, active-high), btn (raw async level),
//        level (accepted debounced level), press (one-cycle rising pulse).
module btn_debounce
    import timer_pkg::*;
#(
    parameter int DB = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level,
    output logic press
);

    localparam int DBC = (DB < 1) ? 1 : DB;
    localparam int CW  = cnt_width(DBC);
    localparam logic [CW-1:0] DB_LAST = CW'(DBC - 1);

    logic          sync1;
    logic          sync2;
    logic          level_d;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
            press   <= 1'b0;
            cnt     <= '0;
        end else begin
            sync1   <= btn;
            sync2   <= sync1;
            level_d <= level;
            press   <= level & ~level_d;
            // Any return to the accepted level restarts the stability count.
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == DB_LAST) begin
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/timer_mode_ctrl.sv
// Mode controller for the mm:ss timer: debounced buttons, OFF/RUN/PAUSE/SET
// FSM, 1 Hz count enable, increment strobes, SET timeout and digit blink.
// Ports: clk, rst (sync, active-high); btn_power/pause/set/inc raw inputs;
//        power_on, tick_1hz, inc_min, inc_sec, set_field[1:0], blink, led_state.
// Optional: define AUTO_REPEAT_EN for held-increment auto-repeat in SET states.
module timer_mode_ctrl
    import timer_pkg::*;
#(
    parameter int CLK_HZ          = 50_000_000,
    parameter int DEBOUNCE_MS     = 10,
    parameter int SET_TIMEOUT_S   = 10,
    parameter int REPEAT_DELAY_MS = 500,
    parameter int REPEAT_RATE_MS  = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_power,
    input  logic       btn_pause,
    input  logic       btn_set,
    input  logic       btn_inc,
    output logic       power_on,
    output logic       tick_1hz,
    output logic       inc_min,
    output logic       inc_sec,
    output logic [1:0] set_field,
    output logic       blink,
    output logic       led_state
);

    localparam int DB   = ms_to_cycles(CLK_HZ, DEBOUNCE_MS);
    localparam int TO_R = s_to_cycles(CLK_HZ, SET_TIMEOUT_S);
    localparam int TO   = (TO_R < 1) ? 1 : TO_R;
    localparam int HF_R = CLK_HZ / 4;
    localparam int HALF = (HF_R < 1) ? 1 : HF_R;
    localparam int PC   = (CLK_HZ < 1) ? 1 : CLK_HZ;

    localparam int PW = cnt_width(PC);
    localparam int TW = cnt_width(TO);
    localparam int BW = cnt_width(HALF);

    localparam logic [PW-1:0] PRESC_LAST = PW'(PC - 1);
    localparam logic [TW-1:0] TO_LAST    = TW'(TO - 1);
    localparam logic [BW-1:0] HALF_LAST  = BW'(HALF);

    logic prs_power;
    logic prs_pause;
    logic prs_set;
    logic prs_inc;
    logic rep_fire;

    btn_debounce #(.DB(DB)) u_db_power (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_power),
        .level (),
        .press (prs_power)
    );

    btn_debounce #(.DB(DB)) u_db_pause (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_pause),
        .level (),
        .press (prs_pause)
    );

    btn_debounce #(.DB(DB)) u_db_set (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_set),
        .level (),
        .press (prs_set)
    );

`ifdef AUTO_REPEAT_EN
    logic lvl_inc;
`endif

    btn_debounce #(.DB(DB)) u_db_inc (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_inc),
`ifdef AUTO_REPEAT_EN
        .level (lvl_inc),
`else
        .level (),
`endif
        .press (prs_inc)
    );

    state_t state_q;
    state_t state_nxt;

    logic ev_power;
    logic ev_set;
    logic ev_pause;
    logic ev_inc;
    logic inc_ev;
    logic any_press;
    logic in_set;
    logic set_nxt;
    logic timeout;

    logic [PW-1:0] presc;
    logic [TW-1:0] to_cnt;
    logic [BW-1:0] blink_cnt;
    logic          blink_q;

    // Fixed priority; a lower-priority press in the same cycle is dropped.
    assign ev_power = prs_power;
    assign ev_set   = prs_set & ~prs_power;
    assign ev_pause = prs_pause & ~prs_power & ~prs_set;
    assign ev_inc   = prs_inc & ~prs_power & ~prs_set & ~prs_pause;
    assign inc_ev   = ev_inc | rep_fire;

    assign any_press = prs_power | prs_pause | prs_set | prs_inc | rep_fire;

    assign in_set  = (state_q == ST_SET_MIN) || (state_q == ST_SET_SEC);
    assign set_nxt = (state_nxt == ST_SET_MIN) || (state_nxt == ST_SET_SEC);
    assign timeout = in_set && (to_cnt == TO_LAST) && !any_press;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_OFF;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        power_on  = 1'b1;
        led_state = 1'b0;
        set_field = FIELD_NONE;
        unique case (state_q)
            ST_OFF: begin
                power_on = 1'b0;
                if (ev_power) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                led_state = 1'b1;
                if (ev_power)      state_nxt = ST_OFF;
                else if (ev_set)   state_nxt = ST_SET_MIN;
                else if (ev_pause) state_nxt = ST_PAUSE;
            end
            ST_PAUSE: begin
                if (ev_power)      state_nxt = ST_OFF;
                else if (ev_set)   state_nxt = ST_SET_MIN;
                else if (ev_pause) state_nxt = ST_RUN;
            end
            ST_SET_MIN: begin
                set_field = FIELD_MIN;
                if (ev_power)     state_nxt = ST_OFF;
                else if (ev_set)  state_nxt = ST_SET_SEC;
                else if (timeout) state_nxt = ST_PAUSE;
            end
            ST_SET_SEC: begin
                set_field = FIELD_SEC;
                if (ev_power)     state_nxt = ST_OFF;
                else if (ev_set)  state_nxt = ST_PAUSE;
                else if (timeout) state_nxt = ST_PAUSE;
            end
            default: begin
                power_on  = 1'b0;
                state_nxt = ST_OFF;
            end
        endcase
    end

    // Prescaler runs only in RUN, holds elsewhere, clears in OFF. The tick
    // follows the wrap even when RUN is left on the wrap cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc    <= '0;
            tick_1hz <= 1'b0;
        end else begin
            tick_1hz <= (state_q == ST_RUN) && (presc == PRESC_LAST);
            if (state_q == ST_OFF) begin
                presc <= '0;
            end else if (state_q == ST_RUN) begin
                if (presc == PRESC_LAST) presc <= '0;
                else                     presc <= presc + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inc_min <= 1'b0;
            inc_sec <= 1'b0;
        end else begin
            inc_min <= inc_ev && (state_q == ST_SET_MIN);
            inc_sec <= inc_ev && (state_q == ST_SET_SEC);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !in_set || any_press || (state_nxt != state_q)) begin
            to_cnt <= '0;
        end else if (to_cnt != TO_LAST) begin
            to_cnt <= to_cnt + TW'(1);
        end
    end

    // Blink phase restarts at 1 on SET entry and free-runs between fields.
    always_ff @(posedge clk) begin
        if (rst || !set_nxt) begin
            blink_cnt <= '0;
            blink_q   <= 1'b0;
        end else if (!in_set) begin
            blink_cnt <= BW'(1);
            blink_q   <= 1'b0;
        end else if (blink_cnt == HALF_LAST) begin
            blink_cnt <= BW'(1);
            blink_q   <= ~blink_q;
        end else begin
            blink_cnt <= blink_cnt + BW'(1);
        end
    end

    assign blink = blink_q;

`ifdef AUTO_REPEAT_EN
    localparam int RD_R = ms_to_cycles(CLK_HZ, REPEAT_DELAY_MS);
    localparam int RR_R = ms_to_cycles(CLK_HZ, REPEAT_RATE_MS);
    localparam int RD   = (RD_R < 1) ? 1 : RD_R;
    localparam int RR   = (RR_R < 1) ? 1 : RR_R;
    localparam int RW   = cnt_width((RD > RR) ? RD : RR);
    localparam logic [RW-1:0] RD_L = RW'(RD);
    localparam logic [RW-1:0] RR_L = RW'(RR);

    logic [RW-1:0] rep_cnt;
    logic          rep_armed;
    logic          rep_hit;

    // Counter holds cycles since the press (or since the last repeat).
    assign rep_hit  = rep_armed ? (rep_cnt == RR_L) : (rep_cnt == RD_L);
    assign rep_fire = in_set && lvl_inc && rep_hit &&
                      !prs_inc && !prs_power && !prs_set && !prs_pause;

    always_ff @(posedge clk) begin
        if (rst || !(in_set && lvl_inc) || (state_nxt != state_q)) begin
            rep_cnt   <= '0;
            rep_armed <= 1'b0;
        end else if (prs_inc) begin
            rep_cnt   <= RW'(1);
            rep_armed <= 1'b0;
        end else if (rep_hit) begin
            rep_cnt   <= RW'(1);
            rep_armed <= 1'b1;
        end else begin
            rep_cnt <= rep_cnt + RW'(1);
        end
    end
`else
    assign rep_fire = 1'b0;
`endif

endmodule

// File: tb/tb_timer_mode_ctrl.sv
// Self-checking bench for timer_mode_ctrl with small clock constants.
// Table of button presses with expected mode outputs plus timing sequences.
module tb_timer_mode_ctrl;

    localparam int CLK_HZ = 1000;
    localparam int B_POWER = 1;
    localparam int B_PAUSE = 2;
    localparam int B_SET   = 3;
    localparam int B_INC   = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_power = 1'b0;
    logic       btn_pause = 1'b0;
    logic       btn_set = 1'b0;
    logic       btn_inc = 1'b0;
    logic       power_on;
    logic       tick_1hz;
    logic       inc_min;
    logic       inc_sec;
    logic [1:0] set_field;
    logic       blink;
    logic       led_state;

    timer_mode_ctrl #(
        .CLK_HZ          (CLK_HZ),
        .DEBOUNCE_MS     (2),
        .SET_TIMEOUT_S   (1),
        .REPEAT_DELAY_MS (20),
        .REPEAT_RATE_MS  (5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_power (btn_power),
        .btn_pause (btn_pause),
        .btn_set   (btn_set),
        .btn_inc   (btn_inc),
        .power_on  (power_on),
        .tick_1hz  (tick_1hz),
        .inc_min   (inc_min),
        .inc_sec   (inc_sec),
        .set_field (set_field),
        .blink     (blink),
        .led_state (led_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    int n_min = 0;
    int n_sec = 0;
    int n_tick = 0;
    int both_cnt = 0;
    int led_edges = 0;
    int led_fall_cyc = -1;
    bit set_seen = 0;
    logic led_prev = 1'b0;
    int sec_q[$];

    always @(negedge clk) begin
        if (inc_min) n_min++;
        if (inc_sec) begin
            n_sec++;
            sec_q.push_back(cyc);
        end
        if (tick_1hz) n_tick++;
        if (inc_min && inc_sec) both_cnt++;
        if (set_field != 2'b00) set_seen = 1;
        if (led_state != led_prev) led_edges++;
        if (led_prev && !led_state) led_fall_cyc = cyc;
        led_prev = led_state;
    end

    typedef struct {
        int         btn;
        logic       po;
        logic       led;
        logic [1:0] fld;
        int         dmin;
        int         dsec;
    } vec_t;

    vec_t tbl[17];
    vec_t sb_q[$];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input int b, input logic v);
        case (b)
            B_POWER: btn_power = v;
            B_PAUSE: btn_pause = v;
            B_SET:   btn_set = v;
            B_INC:   btn_inc = v;
            default: ;
        endcase
    endtask

    task automatic press(input int b);
        drive(b, 1'b1);
        repeat (8) @(negedge clk);
        drive(b, 1'b0);
        repeat (10) @(negedge clk);
    endtask

    function automatic int cur(input int sel);
        case (sel)
            0: return int'(tick_1hz);
            1: return int'(led_state);
            2: return int'(set_field);
            default: return int'(power_on);
        endcase
    endfunction

    task automatic wait_out(input int sel, input int val, input int bound,
                            input string name, output int at);
        bit ok;
        ok = 0;
        at = -1;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (cur(sel) == val) begin
                ok = 1;
                at = cyc;
                break;
            end
        end
        chk(name, ok, 1);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    function automatic vec_t mk(input int b, input logic po, input logic led,
                                input logic [1:0] f, input int dm, input int ds);
        vec_t v;
        v.btn = b; v.po = po; v.led = led; v.fld = f; v.dmin = dm; v.dsec = ds;
        return v;
    endfunction

    logic [7:0] outs;
    assign outs = {power_on, tick_1hz, inc_min, inc_sec,
                   set_field, blink, led_state};

    initial begin
        int t0, t1, tn, pp, rr, e, r2, m0, s0;
        vec_t ex;

        tbl[0]  = mk(B_POWER, 1, 1, 2'b00, 0, 0);
        tbl[1]  = mk(B_PAUSE, 1, 0, 2'b00, 0, 0);
        tbl[2]  = mk(B_SET,   1, 0, 2'b01, 0, 0);
        tbl[3]  = mk(B_INC,   1, 0, 2'b01, 1, 0);
        tbl[4]  = mk(B_INC,   1, 0, 2'b01, 1, 0);
        tbl[5]  = mk(B_INC,   1, 0, 2'b01, 1, 0);
        tbl[6]  = mk(B_PAUSE, 1, 0, 2'b01, 0, 0);
        tbl[7]  = mk(B_SET,   1, 0, 2'b10, 0, 0);
        tbl[8]  = mk(B_INC,   1, 0, 2'b10, 0, 1);
        tbl[9]  = mk(B_SET,   1, 0, 2'b00, 0, 0);
        tbl[10] = mk(B_INC,   1, 0, 2'b00, 0, 0);
        tbl[11] = mk(B_PAUSE, 1, 1, 2'b00, 0, 0);
        tbl[12] = mk(B_SET,   1, 0, 2'b01, 0, 0);
        tbl[13] = mk(B_POWER, 0, 0, 2'b00, 0, 0);
        tbl[14] = mk(B_INC,   0, 0, 2'b00, 0, 0);
        tbl[15] = mk(B_SET,   0, 0, 2'b00, 0, 0);
        tbl[16] = mk(B_PAUSE, 0, 0, 2'b00, 0, 0);

        repeat (3) @(negedge clk);
        chk("reset outputs", outs, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle after reset", outs, 0);

        // Power on, then tick period.
        btn_power = 1'b1;
        wait_out(1, 1, 20, "power led", e);
        chk("power_on", power_on, 1);
        btn_power = 1'b0;
        wait_out(0, 1, 1100, "first tick", t0);
        @(negedge clk);
        chk("tick one cycle", tick_1hz, 0);
        wait_out(0, 1, 1100, "second tick", t1);
        chk("tick period", t1 - t0, 1000);

        // Bouncing pause button, then a clean hold.
        led_edges = 0;
        for (int i = 0; i < 10; i++) begin
            btn_pause = ~btn_pause;
            @(negedge clk);
        end
        btn_pause = 1'b1;
        repeat (12) @(negedge clk);
        btn_pause = 1'b0;
        repeat (10) @(negedge clk);
        chk("bounce one press", led_edges, 1);
        chk("pause led", led_state, 0);
        pp = led_fall_cyc;
        m0 = n_tick;
        repeat (300) @(negedge clk);
        chk("no tick paused", n_tick - m0, 0);
        btn_pause = 1'b1;
        wait_out(1, 1, 20, "resume led", rr);
        btn_pause = 1'b0;
        wait_out(0, 1, 1100, "resume tick", tn);
        chk("resume tick cycle", tn, rr + 1000 - (pp - t1));

        // Power and set together from RUN.
        set_seen = 0;
        btn_power = 1'b1;
        btn_set = 1'b1;
        repeat (10) @(negedge clk);
        btn_power = 1'b0;
        btn_set = 1'b0;
        repeat (10) @(negedge clk);
        chk("power+set off", power_on, 0);
        chk("power+set no set", set_seen, 0);
        m0 = n_tick;
        repeat (1100) @(negedge clk);
        chk("no tick in off", n_tick - m0, 0);

        foreach (tbl[i]) begin
            m0 = n_min;
            s0 = n_sec;
            sb_q.push_back(tbl[i]);
            press(tbl[i].btn);
            ex = sb_q.pop_front();
            chk($sformatf("vec%0d mode", i), {power_on, led_state, set_field},
                {ex.po, ex.led, ex.fld});
            chk($sformatf("vec%0d inc_min", i), n_min - m0, ex.dmin);
            chk($sformatf("vec%0d inc_sec", i), n_sec - s0, ex.dsec);
        end

        // SET timeout and blink phase.
        press(B_POWER);
        btn_set = 1'b1;
        wait_out(2, 1, 20, "set entry", e);
        btn_set = 1'b0;
        chk("blink at entry", blink, 0);
        wait_until(e + 249);
        chk("blink low half", blink, 0);
        wait_until(e + 250);
        chk("blink high half", blink, 1);
        wait_until(e + 999);
        chk("set before timeout", set_field, 1);
        wait_until(e + 1000);
        chk("timeout field", set_field, 0);
        chk("timeout pause", {power_on, led_state}, 2'b10);

        // Reset in RUN with prescaler at 500.
        press(B_POWER);
        btn_power = 1'b1;
        wait_out(1, 1, 20, "rerun led", rr);
        btn_power = 1'b0;
        wait_until(rr + 500);
        rst = 1'b1;
        @(negedge clk);
        chk("mid reset outputs", outs, 0);
        rst = 1'b0;
        m0 = n_tick;
        repeat (1100) @(negedge clk);
        chk("no tick after reset", n_tick - m0, 0);
        chk("off after reset", power_on, 0);
        btn_power = 1'b1;
        wait_out(1, 1, 20, "run after reset", r2);
        btn_power = 1'b0;
        wait_out(0, 1, 1100, "tick after reset", tn);
        chk("prescaler cleared", tn, r2 + 1000);

        // Held increment in SET_SEC.
        press(B_SET);
        press(B_SET);
        chk("in set_sec", set_field, 2);
        s0 = n_sec;
        sec_q.delete();
        btn_inc = 1'b1;
        repeat (40) @(negedge clk);
        btn_inc = 1'b0;
        repeat (20) @(negedge clk);
`ifdef AUTO_REPEAT_EN
        chk("repeat count", n_sec - s0, 5);
        if (sec_q.size() == 5) begin
            int gaps[4];
            gaps = '{20, 25, 30, 35};
            for (int k = 0; k < 4; k++)
                chk($sformatf("repeat gap%0d", k), sec_q[k+1] - sec_q[0], gaps[k]);
        end
`else
        chk("held inc single", n_sec - s0, 1);
`endif
        chk("never both strobes", both_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
